// File: rtl/rf_dump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_dump: register-file debug readout. On start, each register is swept   |
// | in order and streamed out over valid/ready with its index attached.      |
// | Optional trailing checksum word is built in with RF_DUMP_CHECKSUM_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rf_dump #(
  parameter int bw = 8,
  parameter int aw = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [aw-1:0] ra,
  input  logic [bw-1:0] a,
  output logic [bw-1:0] out_data,
  output logic [aw-1:0] out_idx,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [aw-1:0] c_last_idx = {aw{1'b1}};

`ifdef RF_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd3,
    S_CHK   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd3
  } state_t;
`endif

  state_t        r_state;
  logic [aw-1:0] r_idx;
  logic [bw-1:0] r_data;
  logic [aw-1:0] r_oidx;
  logic          r_last;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
`ifdef RF_DUMP_CHECKSUM_EN
  logic [bw-1:0] r_acc;
`endif

  logic w_hs;
  assign w_hs = r_valid && out_ready;

  // The index register doubles as the read address; it is parked at 0 in IDLE.
  assign ra        = r_idx;
  assign out_data  = r_data;
  assign out_idx   = r_oidx;
  assign out_last  = r_last;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_oidx  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
      r_acc   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
`ifdef RF_DUMP_CHECKSUM_EN
            r_acc   <= '0;
`endif
          end
        end

        S_FETCH: begin
          r_data  <= a;
          r_oidx  <= r_idx;
`ifdef RF_DUMP_CHECKSUM_EN
          r_acc   <= r_acc + a;
          r_last  <= 1'b0;
`else
          r_last  <= (r_idx == c_last_idx);
`endif
          r_valid <= 1'b1;
          r_state <= S_SEND;
        end

        S_SEND: begin
          if (w_hs) begin
            if (r_idx == c_last_idx) begin
`ifdef RF_DUMP_CHECKSUM_EN
              // Valid stays high: the checksum word follows back-to-back.
              r_data  <= r_acc;
              r_oidx  <= '0;
              r_last  <= 1'b1;
              r_state <= S_CHK;
`else
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= S_FETCH;
            end
          end
        end

`ifdef RF_DUMP_CHECKSUM_EN
        S_CHK: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          r_done  <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
